// File: rtl/data_encoder_decoder_unit.sv
// Word <-> byte bridge between word-wide memory traffic and a byte-wide UART.
// TX splits a WORD_SIZE word into N UART bytes (LSB first) and handshakes each
// byte with the UART transmitter; RX reassembles N received bytes into a word.
// The two directions share nothing but clock and reset.
module data_encoder_decoder_unit #(
  parameter int WORD_SIZE  = 24,
  parameter int UART_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  // memory side
  input  logic [WORD_SIZE-1:0]  dataFromMem,
  input  logic                  txStart,
  output logic                  txReady,
  output logic [WORD_SIZE-1:0]  dataToMem,
  output logic                  rxDone,
  output logic                  new_rx_data_indicate,
  // UART side
  input  logic                  txByteReady,
  output logic                  txByteStart,
  output logic [UART_WIDTH-1:0] byteForTx,
  input  logic                  rxByteReady,
  input  logic                  rx_new_byte_indicate,
  input  logic [UART_WIDTH-1:0] byteFromRx
);

  // bytes per word, rounded up; the last byte carries zero padding if needed
  localparam int N  = WORD_SIZE / UART_WIDTH + ((WORD_SIZE % UART_WIDTH) != 0 ? 1 : 0);
  localparam int NW = N * UART_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

  // ---------------------------------------------------------------- TX path
  tx_state_t        tx_st, tx_nxt;
  logic [NW-1:0]    tx_word;
  logic [CW-1:0]    tx_cnt;
  logic             tx_load, tx_put, tx_shift, tx_inc;

  // state register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) tx_st <= IDLE;
    else       tx_st <= tx_nxt;
  end

  // next-state and datapath strobes; the UART handshake is ready -> start
  // pulse -> ready low (accepted) -> ready high (byte finished)
  always_comb begin
    tx_nxt   = tx_st;
    tx_load  = 1'b0;
    tx_put   = 1'b0;
    tx_shift = 1'b0;
    tx_inc   = 1'b0;
    case (tx_st)
      IDLE: begin
        if (txStart) begin
          tx_load = 1'b1;
          tx_nxt  = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (txByteReady) begin
          tx_put = 1'b1;
          tx_nxt = START;
        end
      end
      START: tx_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!txByteReady) tx_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (txByteReady) begin
          tx_inc = 1'b1;
          if (tx_cnt == LAST) begin
            tx_nxt = IDLE;
          end else begin
            tx_shift = 1'b1;
            tx_nxt   = WAIT_RDY;
          end
        end
      end
      default: tx_nxt = IDLE;
    endcase
  end

  assign txReady     = (tx_st == IDLE);
  assign txByteStart = (tx_st == START);

  // word shifter, byte counter and the byte held for the UART; the presented
  // byte only changes when the next one is loaded so it stays stable while
  // the UART shifts it out
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tx_word   <= '0;
      tx_cnt    <= '0;
      byteForTx <= '0;
    end else begin
      if (tx_load) begin
        tx_word <= NW'(dataFromMem);
        tx_cnt  <= '0;
      end
      if (tx_shift) tx_word   <= tx_word >> UART_WIDTH;
      if (tx_inc)   tx_cnt    <= tx_cnt + 1'b1;
      if (tx_put)   byteForTx <= tx_word[UART_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [NW-1:0]            rx_asm;
  logic [CW-1:0]            rx_cnt;
  logic [NW+UART_WIDTH-1:0] rx_cat;
  logic [NW-1:0]            rx_next;

  // new byte enters at the top and slides down, so after N bytes the first
  // byte received sits in the least-significant position
  assign rx_cat  = {byteFromRx, rx_asm};
  assign rx_next = rx_cat[NW+UART_WIDTH-1:UART_WIDTH];

  // byte assembly, word hand-off and completion flags
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_asm               <= '0;
      rx_cnt               <= '0;
      dataToMem            <= '0;
      rxDone               <= 1'b0;
      new_rx_data_indicate <= 1'b0;
    end else begin
      new_rx_data_indicate <= 1'b0;
      if (rx_new_byte_indicate) begin
        rx_asm <= rx_next;
        if (rx_cnt == LAST) begin
          rx_cnt               <= '0;
          dataToMem            <= rx_next[WORD_SIZE-1:0];
          rxDone               <= 1'b1;
          new_rx_data_indicate <= 1'b1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
          rxDone <= 1'b0;
        end
      end
    end
  end

  // receiver-idle level is informational; pad bits of the last byte and the
  // byte shifted out of the bottom of the assembler are dropped
  logic unused_rx;
  assign unused_rx = &{1'b0, rxByteReady, rx_cat[UART_WIDTH-1:0], rx_next};

endmodule

// File: tb/tb_data_encoder_decoder_unit.sv
// Directed bench: a 24-bit instance (no padding) and a 20-bit instance (padded
// last byte) share the memory-side and RX inputs; each has its own simple
// UART transmitter model that records the bytes it is asked to send.
module tb_data_encoder_decoder_unit;

  logic        clk = 1'b0;
  logic        rstN;
  always #5 clk = ~clk;

  logic [23:0] data_from_mem;
  logic        tx_start;
  logic        rx_pulse;
  logic [7:0]  rx_byte;
  logic        rx_idle;

  logic        tx_ready_a, rx_done_a, new_rx_a, tx_bstart_a, tx_rdy_a;
  logic [23:0] data_to_mem_a;
  logic [7:0]  byte_tx_a;

  logic        tx_ready_b, rx_done_b, new_rx_b, tx_bstart_b, tx_rdy_b;
  logic [19:0] data_to_mem_b;
  logic [7:0]  byte_tx_b;

  data_encoder_decoder_unit #(.WORD_SIZE(24), .UART_WIDTH(8)) dut_a (
    .clk(clk), .rstN(rstN),
    .dataFromMem(data_from_mem), .txStart(tx_start), .txReady(tx_ready_a),
    .dataToMem(data_to_mem_a), .rxDone(rx_done_a), .new_rx_data_indicate(new_rx_a),
    .txByteReady(tx_rdy_a), .txByteStart(tx_bstart_a), .byteForTx(byte_tx_a),
    .rxByteReady(rx_idle), .rx_new_byte_indicate(rx_pulse), .byteFromRx(rx_byte)
  );

  data_encoder_decoder_unit #(.WORD_SIZE(20), .UART_WIDTH(8)) dut_b (
    .clk(clk), .rstN(rstN),
    .dataFromMem(data_from_mem[19:0]), .txStart(tx_start), .txReady(tx_ready_b),
    .dataToMem(data_to_mem_b), .rxDone(rx_done_b), .new_rx_data_indicate(new_rx_b),
    .txByteReady(tx_rdy_b), .txByteStart(tx_bstart_b), .byteForTx(byte_tx_b),
    .rxByteReady(rx_idle), .rx_new_byte_indicate(rx_pulse), .byteFromRx(rx_byte)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] bytes_a[$];
  logic [7:0] bytes_b[$];
  int pulses_a = 0, pulses_b = 0, nrx_a = 0;

  // UART transmitter models: accept on the start pulse, stay busy 4 cycles
  initial begin
    tx_rdy_a = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_bstart_a === 1'b1) begin
        bytes_a.push_back(byte_tx_a);
        tx_rdy_a = 1'b0;
        repeat (4) @(negedge clk);
        tx_rdy_a = 1'b1;
      end
    end
  end

  initial begin
    tx_rdy_b = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_bstart_b === 1'b1) begin
        bytes_b.push_back(byte_tx_b);
        tx_rdy_b = 1'b0;
        repeat (4) @(negedge clk);
        tx_rdy_b = 1'b1;
      end
    end
  end

  // pulse counters (catch stretched or repeated pulses)
  initial forever begin
    @(negedge clk);
    if (tx_bstart_a === 1'b1) pulses_a++;
    if (tx_bstart_b === 1'b1) pulses_b++;
    if (new_rx_a === 1'b1)    nrx_a++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (tx_ready_a === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL tx_idle_timeout: txReady still low after 400 cycles");
    end
  endtask

  task automatic do_tx(input logic [23:0] w);
    @(negedge clk);
    data_from_mem = w;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("tx_ready_drop", {31'b0, tx_ready_a}, 32'h0);
    chk("tx_start_latency", {31'b0, tx_bstart_a}, 32'h0);
    wait_idle();
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_pulse = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_pulse = 1'b0;
  endtask

  typedef struct {
    logic [23:0] word;
    logic [7:0]  b0, b1, b2;
  } tx_vec_t;

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [23:0] w24;
    logic [19:0] w20;
  } rx_vec_t;

  tx_vec_t txv[5];
  rx_vec_t rxv[5];

  initial begin
    int p0, pb0, n0;
    logic [23:0] prev;

    txv[0] = '{24'hA1B2C3, 8'hC3, 8'hB2, 8'hA1};
    txv[1] = '{24'h000000, 8'h00, 8'h00, 8'h00};
    txv[2] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF};
    txv[3] = '{24'h123456, 8'h56, 8'h34, 8'h12};
    txv[4] = '{24'h800001, 8'h01, 8'h00, 8'h80};

    rxv[0] = '{8'h11, 8'h22, 8'h33, 24'h332211, 20'h32211};
    rxv[1] = '{8'hDE, 8'hAD, 8'hBE, 24'hBEADDE, 20'hEADDE};
    rxv[2] = '{8'h00, 8'h00, 8'h00, 24'h000000, 20'h00000};
    rxv[3] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF, 20'hFFFFF};
    rxv[4] = '{8'h5A, 8'hC3, 8'h0F, 24'h0FC35A, 20'hFC35A};

    data_from_mem = '0;
    tx_start = 1'b0;
    rx_pulse = 1'b0;
    rx_byte  = '0;
    rx_idle  = 1'b1;

    // reset state, and it must persist with idle inputs
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", {31'b0, tx_ready_a}, 32'h1);
    chk("rst_tx_bstart", {31'b0, tx_bstart_a}, 32'h0);
    chk("rst_byte_tx", {24'b0, byte_tx_a}, 32'h0);
    chk("rst_data_to_mem", {8'b0, data_to_mem_a}, 32'h0);
    chk("rst_rx_done", {31'b0, rx_done_a}, 32'h0);
    chk("rst_new_rx", {31'b0, new_rx_a}, 32'h0);
    rstN = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_tx_ready", {31'b0, tx_ready_a}, 32'h1);
    chk("idle_data_to_mem", {8'b0, data_to_mem_a}, 32'h0);
    chk("idle_rx_done", {31'b0, rx_done_a}, 32'h0);

    // TX table: LSB first, exactly three pulses per word
    foreach (txv[i]) begin
      bytes_a.delete();
      p0 = pulses_a;
      do_tx(txv[i].word);
      chk("tx_nbytes", bytes_a.size(), 3);
      chk("tx_byte0", {24'b0, bytes_a[0]}, {24'b0, txv[i].b0});
      chk("tx_byte1", {24'b0, bytes_a[1]}, {24'b0, txv[i].b1});
      chk("tx_byte2", {24'b0, bytes_a[2]}, {24'b0, txv[i].b2});
      chk("tx_pulses", pulses_a - p0, 3);
      chk("tx_ready_end", {31'b0, tx_ready_a}, 32'h1);
    end

    // RX table: words back to back, old word held until the new one completes
    prev = '0;
    foreach (rxv[i]) begin
      n0 = nrx_a;
      send_rx(rxv[i].b0);
      chk("rx_done_fall", {31'b0, rx_done_a}, 32'h0);
      send_rx(rxv[i].b1);
      chk("rx_hold", {8'b0, data_to_mem_a}, {8'b0, prev});
      chk("rx_done_partial", {31'b0, rx_done_a}, 32'h0);
      send_rx(rxv[i].b2);
      @(negedge clk);
      chk("rx_word24", {8'b0, data_to_mem_a}, {8'b0, rxv[i].w24});
      chk("rx_word20", {12'b0, data_to_mem_b}, {12'b0, rxv[i].w20});
      chk("rx_done", {31'b0, rx_done_a}, 32'h1);
      chk("rx_new_pulses", nrx_a - n0, 1);
      prev = rxv[i].w24;
    end

    // txStart during a transfer is ignored
    bytes_a.delete();
    p0 = pulses_a;
    @(negedge clk);
    data_from_mem = 24'hA1B2C3;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (6) @(negedge clk);
    data_from_mem = 24'h999999;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("busy_pulses", pulses_a - p0, 3);
    chk("busy_byte2", {24'b0, bytes_a[2]}, 32'hA1);
    chk("busy_idle", {31'b0, tx_ready_a}, 32'h1);

    // five words back to back -> fifteen bytes
    p0 = pulses_a;
    for (int i = 0; i < 5; i++) do_tx(24'h010203 + 24'(i));
    chk("b2b_pulses", pulses_a - p0, 15);

    // padded 20-bit instance
    bytes_b.delete();
    pb0 = pulses_b;
    do_tx(24'h0ABCDE);
    chk("pad_nbytes", bytes_b.size(), 3);
    chk("pad_tx0", {24'b0, bytes_b[0]}, 32'hDE);
    chk("pad_tx1", {24'b0, bytes_b[1]}, 32'hBC);
    chk("pad_tx2", {24'b0, bytes_b[2]}, 32'h0A);
    chk("pad_pulses", pulses_b - pb0, 3);
    send_rx(8'hDE);
    send_rx(8'hBC);
    send_rx(8'hFA);
    @(negedge clk);
    chk("pad_rx20", {12'b0, data_to_mem_b}, 32'hABCDE);
    chk("pad_rx24", {8'b0, data_to_mem_a}, 32'hFABCDE);

    // full duplex: TX and RX at once
    bytes_a.delete();
    fork
      do_tx(24'h0F1E2D);
      begin
        send_rx(8'h01);
        send_rx(8'h02);
        send_rx(8'h03);
      end
    join
    @(negedge clk);
    chk("dup_rx", {8'b0, data_to_mem_a}, 32'h030201);
    chk("dup_tx0", {24'b0, bytes_a[0]}, 32'h2D);
    chk("dup_tx2", {24'b0, bytes_a[2]}, 32'h0F);

    // reset with a partial RX word and TX mid byte 2
    send_rx(8'h77);
    p0 = pulses_a;
    @(negedge clk);
    data_from_mem = 24'h445566;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int i = 0; i < 200 && (pulses_a - p0) < 2; i++) @(negedge clk);
    chk("mid_reached_byte2", pulses_a - p0, 2);
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_ready", {31'b0, tx_ready_a}, 32'h1);
    chk("mid_rst_byte_tx", {24'b0, byte_tx_a}, 32'h0);
    chk("mid_rst_data", {8'b0, data_to_mem_a}, 32'h0);
    chk("mid_rst_rx_done", {31'b0, rx_done_a}, 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (6) @(negedge clk);
    n0 = nrx_a;
    send_rx(8'hAA);
    send_rx(8'hBB);
    chk("post_rst_partial", {31'b0, rx_done_a}, 32'h0);
    send_rx(8'hCC);
    @(negedge clk);
    chk("post_rst_rx", {8'b0, data_to_mem_a}, 32'hCCBBAA);
    chk("post_rst_new", nrx_a - n0, 1);
    bytes_a.delete();
    do_tx(24'h010203);
    chk("post_rst_nbytes", bytes_a.size(), 3);
    chk("post_rst_tx0", {24'b0, bytes_a[0]}, 32'h03);
    chk("post_rst_tx1", {24'b0, bytes_a[1]}, 32'h02);
    chk("post_rst_tx2", {24'b0, bytes_a[2]}, 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
